// File: rtl/sram_responder.sv
// Cycle-sampled async-SRAM slave model: registered read/write FSM with a tristate data bus.
// Optional read/write activity counters are enabled by defining SRAM_RESPONDER_COUNT_EN.
module sram_responder #(
   parameter int unsigned AW = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_en,
   input  logic        ram_oe,
   input  logic        ram_we,
   input  logic [17:0] addr,
   inout  wire  [15:0] data,
`ifdef SRAM_RESPONDER_COUNT_EN
   output logic [15:0] wr_count,
   output logic [15:0] rd_count,
`endif
   output logic        conflict,
   output logic        busy
);

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_TURN  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic [DW-1:0]   dout_q;
   logic            drive_q, drive_d;
   logic            conflict_q, conflict_d;
   logic            busy_q;
   logic            fetch_c;
   logic            commit_c;
   logic            rd_entry_c;
   logic            wr_req_c;
   logic            rd_req_c;
   logic [DW-1:0]   mem_q [DEPTH];
   logic            unused_addr_hi;

   // Upper address bits alias away.
   assign unused_addr_hi = ^addr[17:AW];

   assign wr_req_c = !ram_en && !ram_we;
   assign rd_req_c = !ram_en && !ram_oe;

   // Next-state, latch and bus-direction decisions from the sampled inputs.
   always_comb begin
      state_d    = state_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      raddr_d    = raddr_q;
      drive_d    = 1'b0;
      fetch_c    = 1'b0;
      commit_c   = 1'b0;
      rd_entry_c = 1'b0;
      conflict_d = conflict_q | (!ram_en && !ram_oe && !ram_we);

      case (state_q)
         S_IDLE: begin
            if (wr_req_c) begin
               state_d = S_WRITE;
               waddr_d = addr[AW-1:0];
               wdata_d = data;
            end else if (rd_req_c) begin
               state_d    = S_READ;
               raddr_d    = addr[AW-1:0];
               rd_entry_c = 1'b1;
            end
         end
         S_READ: begin
            if (ram_en) begin
               state_d = S_IDLE;
            end else if (!ram_we) begin
               state_d = S_TURN;
            end else if (ram_oe) begin
               state_d = S_IDLE;
            end else begin
               drive_d = 1'b1;
               fetch_c = 1'b1;
               raddr_d = addr[AW-1:0];
            end
         end
         S_TURN: begin
            if (wr_req_c) begin
               state_d = S_WRITE;
               waddr_d = addr[AW-1:0];
               wdata_d = data;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (wr_req_c) begin
               waddr_d = addr[AW-1:0];
               wdata_d = data;
            end else begin
               commit_c = 1'b1;
               if (rd_req_c) begin
                  state_d = S_READ;
                  raddr_d = addr[AW-1:0];
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         waddr_q    <= '0;
         wdata_q    <= '0;
         raddr_q    <= '0;
         dout_q     <= '0;
         drive_q    <= 1'b0;
         conflict_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         raddr_q    <= raddr_d;
         drive_q    <= drive_d;
         conflict_q <= conflict_d;
         busy_q     <= (state_d != S_IDLE);
         if (fetch_c) begin
            dout_q <= mem_q[raddr_q];
         end
      end
   end

   // Storage array survives reset; commit only ever fires out of WRITE.
   always_ff @(posedge clk) begin
      if (commit_c) begin
         mem_q[waddr_q] <= wdata_q;
      end
   end

`ifdef SRAM_RESPONDER_COUNT_EN
   logic [15:0] wr_count_q;
   logic [15:0] rd_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_q <= '0;
         rd_count_q <= '0;
      end else begin
         if (commit_c) begin
            wr_count_q <= wr_count_q + 16'd1;
         end
         if (rd_entry_c) begin
            rd_count_q <= rd_count_q + 16'd1;
         end
      end
   end

   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;
`endif

   assign data     = drive_q ? dout_q : {DW{1'bz}};
   assign conflict = conflict_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: driver feeds a behavioural model, monitor compares every cycle.
module tb_sram_responder;

   localparam int unsigned AW = 8;

   typedef struct {
      logic        busy;
      logic        conflict;
      logic        drive;
      logic        known;
      logic [15:0] val;
      logic [15:0] wrc;
      logic [15:0] rdc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        ram_en;
   logic        ram_oe;
   logic        ram_we;
   logic [17:0] addr;
   wire  [15:0] data;
   logic        conflict;
   logic        busy;
   logic        tb_drive;
   logic [15:0] tb_data;
`ifdef SRAM_RESPONDER_COUNT_EN
   logic [15:0] wr_count;
   logic [15:0] rd_count;
`endif

   assign data = tb_drive ? tb_data : 16'hzzzz;

   sram_responder #(.AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .ram_en   (ram_en),
      .ram_oe   (ram_oe),
      .ram_we   (ram_we),
      .addr     (addr),
      .data     (data),
`ifdef SRAM_RESPONDER_COUNT_EN
      .wr_count (wr_count),
      .rd_count (rd_count),
`endif
      .conflict (conflict),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   // Reference model: what the memory holds and which transaction is in flight.
   logic [15:0] mem_m [int];
   bit          m_rd, m_turn, m_wr, m_conf;
   int          m_ra, m_wa;
   logic [15:0] m_wd;
   int          m_wrc, m_rdc;

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit en, input bit oe, input bit we,
                             input logic [17:0] a, input logic [15:0] d, output exp_t e);
      int ai;
      ai      = int'(a) % (1 << AW);
      e.drive = 1'b0;
      e.known = 1'b1;
      e.val   = d;
      if (r) begin
         m_rd = 0; m_turn = 0; m_wr = 0; m_conf = 0; m_wrc = 0; m_rdc = 0;
      end else begin
         if (!en && !oe && !we) m_conf = 1;
         if (m_wr) begin
            if (!en && !we) begin
               m_wa = ai; m_wd = d;
            end else begin
               mem_m[m_wa] = m_wd;
               m_wrc = (m_wrc + 1) % 65536;
               m_wr = 0;
               if (!en && !oe) begin
                  m_rd = 1; m_ra = ai;
               end
            end
         end else if (m_turn) begin
            m_turn = 0;
            if (!en && !we) begin
               m_wr = 1; m_wa = ai; m_wd = d;
            end
         end else if (m_rd) begin
            if (en || !we || oe) begin
               m_rd   = 0;
               m_turn = !en && !we;
            end else begin
               e.drive = 1'b1;
               e.known = mem_m.exists(m_ra);
               e.val   = e.known ? mem_m[m_ra] : 16'h0000;
               m_ra    = ai;
            end
         end else begin
            if (!en && !we) begin
               m_wr = 1; m_wa = ai; m_wd = d;
            end else if (!en && !oe) begin
               m_rd = 1; m_ra = ai;
               m_rdc = (m_rdc + 1) % 65536;
            end
         end
      end
      e.busy     = m_rd | m_turn | m_wr;
      e.conflict = m_conf;
      e.wrc      = 16'(m_wrc);
      e.rdc      = 16'(m_rdc);
   endtask

   // One clock of stimulus: apply at negedge, predict, hand the bus over just after the edge.
   task automatic cyc(input bit r, input bit en, input bit oe, input bit we,
                      input logic [17:0] a, input logic [15:0] d);
      exp_t e;
      @(negedge clk);
      rst = r; ram_en = en; ram_oe = oe; ram_we = we; addr = a; tb_data = d;
      model_step(r, en, oe, we, a, d, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      tb_drive = !e.drive;
   endtask

   task automatic idle();
      cyc(0, 1, 1, 1, 18'h0, 16'($urandom));
   endtask

   task automatic wr(input logic [17:0] a, input logic [15:0] d);
      cyc(0, 0, 1, 0, a, d);
      cyc(0, 0, 1, 1, a, 16'($urandom));
   endtask

   task automatic rd(input logic [17:0] a);
      cyc(0, 0, 0, 1, a, 16'($urandom));
   endtask

   always begin : monitor
      exp_t e;
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk1("busy", busy, e.busy);
         chk1("conflict", conflict, e.conflict);
         if (e.known) chk16(e.drive ? "read_data" : "bus_released", data, e.val);
`ifdef SRAM_RESPONDER_COUNT_EN
         chk16("wr_count", wr_count, e.wrc);
         chk16("rd_count", rd_count, e.rdc);
`endif
      end
   end

   initial begin
      bit en, oe, we, r;
      rst = 1'b1; ram_en = 1'b1; ram_oe = 1'b1; ram_we = 1'b1;
      addr = '0; tb_data = '0; tb_drive = 1'b1;
      repeat (3) cyc(1, 1, 1, 1, 18'h0, 16'h0);
      idle();

      // Single-cycle write then read back.
      wr(18'h005, 16'h1234);
      rd(18'h005);
      rd(18'h005);
      #2;
      chk16("r30_data", data, 16'h1234);
      chk1("r30_conflict", conflict, 1'b0);
      idle();

      // Ten writes, then one long read walking addresses downwards.
      for (int i = 0; i < 10; i++) wr(18'h010 + 18'(i), 16'(i + 1));
      idle();
      rd(18'h019);
      for (int j = 9; j >= 0; j--) begin
         rd(18'h010 + 18'(j > 0 ? j - 1 : 0));
         #2;
         chk16("r31_desc", data, 16'(j + 1));
      end
      idle();

      // Read followed by write with oe still low: turnaround cycle, then commit.
      wr(18'h020, 16'h7777);
      rd(18'h020);
      rd(18'h020);
      cyc(0, 0, 0, 0, 18'h020, 16'h4242);
      cyc(0, 0, 0, 0, 18'h020, 16'h4242);
      cyc(0, 0, 1, 1, 18'h020, 16'h0F0F);
      idle();
      rd(18'h020);
      rd(18'h020);
      #2;
      chk16("r32_new", data, 16'h4242);
      idle();

      // Simultaneous oe/we: write wins, conflict sticks.
      cyc(0, 0, 0, 0, 18'h030, 16'hBEEF);
      cyc(0, 0, 0, 0, 18'h030, 16'hBEEF);
      cyc(0, 1, 1, 1, 18'h030, 16'h0000);
      idle();
      #2;
      chk1("r33_conflict", conflict, 1'b1);
      rd(18'h030);
      rd(18'h030);
      #2;
      chk16("r33_data", data, 16'hBEEF);
      idle();

      // Reset during a pending write discards it.
      wr(18'h040, 16'h1111);
      cyc(0, 0, 1, 0, 18'h040, 16'h5555);
      cyc(1, 0, 1, 0, 18'h040, 16'h5555);
      #2;
      chk1("r34_busy", busy, 1'b0);
      chk1("r34_conflict", conflict, 1'b0);
      idle();
      rd(18'h040);
      rd(18'h040);
      #2;
      chk16("r34_data", data, 16'h1111);
      idle();

      // Address aliasing on the upper bits.
      wr(18'h30107, 16'hA5A5);
      rd(18'h00007);
      rd(18'h00007);
      #2;
      chk16("r35_alias", data, 16'hA5A5);
      idle();

      // Back-to-back pulses separated by a single we-high cycle.
      cyc(0, 0, 1, 0, 18'h050, 16'hC001);
      cyc(0, 0, 1, 1, 18'h050, 16'h0000);
      cyc(0, 0, 1, 0, 18'h051, 16'hC002);
      cyc(0, 0, 1, 1, 18'h051, 16'h0000);
      idle();
      rd(18'h050);
      rd(18'h051);
      #2;
      chk16("r23_first", data, 16'hC001);
      rd(18'h051);
      #2;
      chk16("r23_second", data, 16'hC002);
      idle();

      // Randomized traffic over a small aliased window.
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         en = ($urandom_range(0, 9) < 2);
         oe = ($urandom_range(0, 1) == 1);
         we = ($urandom_range(0, 2) != 0);
         cyc(r, en, oe, we, {10'($urandom_range(0, 1023)), 8'($urandom_range(0, 15))},
             16'($urandom));
      end
      repeat (3) idle();

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter AW, default 8, meaning implemented address bits (depth 2^AW words of 16 bits).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ram_en  input  1  chip enable, active-low.
REQ-005 ram_oe  input  1  output enable, active-low.
REQ-006 ram_we  input  1  write enable, active-low.
REQ-007 addr  input  18  word address; only addr[AW-1:0] is used.
REQ-008 data  inout  16  bidirectional data bus; driven only in READ, otherwise high-Z.
REQ-009 conflict  output  1  sticky flag, set when ram_oe and ram_we are sampled low together with ram_en low.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 Control inputs, addr and data are sampled on every rising clk edge; decisions use sampled values only.
REQ-012 States: IDLE, READ, WRITE, TURN; registered, one transition per clock edge.
REQ-013 IDLE->READ when en=0, oe=0, we=1; IDLE->WRITE when en=0, we=0.
REQ-014 READ: drive data = mem[addr] starting on the edge after the read condition is sampled (1-cycle latency); a sampled address change updates data on the next edge.
REQ-015 READ->IDLE when en=1 or oe=1 is sampled; data goes high-Z on that same edge.
REQ-016 READ->TURN when we=0 is sampled; TURN releases the bus (high-Z) for exactly one cycle, then goes to WRITE if en=0 and we=0 are still sampled, otherwise to IDLE.
REQ-017 WRITE: latch addr and data every cycle while en=0 and we=0.
REQ-018 WRITE commit: when we=1 or en=1 is sampled, store the last latched data at the last latched address in a single edge, then go to IDLE, or to READ if en=0 and oe=0.
REQ-019 A write commits exactly once per we-low pulse, whatever the pulse length (1 cycle minimum).
REQ-020 en=0, oe=0, we=0 sampled together: write has priority, the bus stays high-Z, and conflict is set to 1 until rst.
REQ-021 Addresses alias modulo 2^AW; upper address bits are ignored without error.
REQ-022 A read of a never-written location returns an undefined value; the bench does not check it.
REQ-023 Back-to-back we pulses separated by one we=1 cycle commit both words.

Reset
REQ-024 While rst is high: state=IDLE, data high-Z, busy=0, conflict=0, write latches cleared.
REQ-025 A write pending in WRITE when rst asserts is discarded, and no memory update occurs.
REQ-026 Memory contents are not cleared by rst and survive a reset.
REQ-027 The first sampling edge after rst deasserts evaluates the inputs from IDLE.

Configuration
REQ-028 Macro SRAM_RESPONDER_COUNT_EN: when defined, the block adds outputs wr_count[15:0] and rd_count[15:0]. Both reset to 0. wr_count increments once per commit, and rd_count once per IDLE/TURN->READ entry. Both wrap from 0xFFFF to 0.
REQ-029 Without SRAM_RESPONDER_COUNT_EN, the counter ports and logic are absent, and all other behaviour is identical.

Verification
REQ-030 Write 0x1234 @0x005 (we low 1 cycle), then read @0x005 -> data=0x1234 one cycle after oe sampled low; conflict=0.
REQ-031 Write 10 words 0x0001..0x000A at addresses 0x010..0x019 (we toggling 0/1), then read them in descending order -> each value matches; with COUNT_EN, wr_count=10 and rd_count=1.
REQ-032 Read @0x020, then assert we=0 with oe still low -> one TURN cycle with data high-Z, then the write commits; a later read returns the new value.
REQ-033 en=0, oe=0, we=0 with data=0xBEEF @0x030 -> bus high-Z, conflict=1 and held, and 0xBEEF stored at 0x030 after we rises.
REQ-034 Assert rst while in WRITE with data 0x5555 @0x040 that previously held 0x1111 -> after rst, a read @0x040 returns 0x1111, busy=0, and counters are 0.
REQ-035 Write 0xA5A5 @0x3_0107 (AW=8), read @0x007 -> returns 0xA5A5 (aliasing).
